dac7611_rx: RTL and testbench

DAC7611_RX -- requirements
Module: dac7611_rx

---
 rtl/dac7611_pkg.sv | 14 +
 rtl/sync_edge.sv | 31 +++
 rtl/dac7611_rx.sv | 134 +++++++++++++
 tb/tb_dac7611_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dac7611_pkg.sv
// Shared types and sizes for the DAC7611 serial receiver.
package dac7611_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int FCNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LOAD,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with a history flop and edge pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/dac7611_rx.sv
// DAC7611 serial bus receiver: shifts sclk/sdi words and
// latches them on ld_n, with clr_n forcing the code to zero.
module dac7611_rx
    import dac7611_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              sdi,
    input  logic              ld_n,
    input  logic              clr_n,
    output logic [DATA_W-1:0] dac_code,
    output logic              code_valid,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [3:0]        bit_cnt
);

    localparam logic [3:0] FULL_CNT = 4'(DATA_W);

    logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
    logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;
    logic ld_lvl_unused, ld_rise, ld_fall;
    logic clr_lvl, clr_rise_unused, clr_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_lvl_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
        .clk   (clk),
        .reset (reset),
        .din   (sdi),
        .level (sdi_lvl),
        .rise  (sdi_rise_unused),
        .fall  (sdi_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ld (
        .clk   (clk),
        .reset (reset),
        .din   (ld_n),
        .level (ld_lvl_unused),
        .rise  (ld_rise),
        .fall  (ld_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clr (
        .clk   (clk),
        .reset (reset),
        .din   (clr_n),
        .level (clr_lvl),
        .rise  (clr_rise_unused),
        .fall  (clr_fall_unused)
    );

    state_t             state, state_nxt;
    logic               clear_en, load_en, shift_en;
    logic [DATA_W-1:0]  shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Clear dominates everything, including a coincident load edge.
    always_comb begin
        state_nxt = state;
        clear_en  = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        if (!clr_lvl) begin
            state_nxt = ST_CLEAR;
            clear_en  = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_SHIFT: begin
                    if (ld_fall) begin
                        state_nxt = ST_LOAD;
                        load_en   = 1'b1;
                    end else if (sclk_rise) begin
                        state_nxt = ST_SHIFT;
                        shift_en  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_rise) state_nxt = ST_IDLE;
                end
                ST_CLEAR: state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            dac_code   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            bit_cnt    <= '0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (clear_en) begin
                shreg    <= '0;
                dac_code <= '0;
                bit_cnt  <= '0;
            end else if (load_en) begin
                bit_cnt <= '0;
                if (bit_cnt == FULL_CNT) begin
                    dac_code   <= shreg;
                    code_valid <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end else if (shift_en) begin
                shreg <= {shreg[DATA_W-2:0], sdi_lvl};
                if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac7611_rx.sv
// Randomized bench for dac7611_rx against a word-level reference model.
module tb_dac7611_rx;
    import dac7611_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic        ld_n = 1'b1;
    logic        clr_n = 1'b1;
    logic [11:0] dac_code;
    logic        code_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [3:0]  bit_cnt;

    dac7611_rx #(.DATA_W(12), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .sdi        (sdi),
        .ld_n       (ld_n),
        .clr_n      (clr_n),
        .dac_code   (dac_code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cv_seen = 0;
    int fe_seen = 0;

    // Reference model state: the word is the last 12 bits sent
    int          m_cnt = 0;
    logic [11:0] m_sh  = '0;
    logic [11:0] m_dac = '0;
    logic [15:0] m_fcnt = '0;
    int          m_cv = 0;
    int          m_fe = 0;

    always @(negedge clk) begin
        if (code_valid) cv_seen++;
        if (frame_err)  fe_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic verify(input string tag);
        check({tag, ".dac"}, 32'(dac_code), 32'(m_dac));
        check({tag, ".fcnt"}, 32'(frame_cnt), 32'(m_fcnt));
        check({tag, ".bcnt"}, 32'(bit_cnt), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
        check({tag, ".cv"}, 32'(cv_seen), 32'(m_cv));
        check({tag, ".fe"}, 32'(fe_seen), 32'(m_fe));
    endtask

    task automatic send_bits(input int n, input logic [31:0] val);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            sdi = val[i];
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
            sclk = 1'b0;
            m_sh = {m_sh[10:0], val[i]};
            m_cnt++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load();
        @(negedge clk);
        ld_n = 1'b0;
        repeat (4) @(negedge clk);
        ld_n = 1'b1;
        repeat (6) @(negedge clk);
        if (m_cnt == 12) begin
            m_dac = m_sh;
            m_fcnt = m_fcnt + 16'd1;
            m_cv++;
        end else begin
            m_fe++;
        end
        m_cnt = 0;
    endtask

    task automatic do_clear(input bit with_ld);
        @(negedge clk);
        clr_n = 1'b0;
        if (with_ld) ld_n = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_low.dac", 32'(dac_code), 32'h0);
        check("clr_low.bcnt", 32'(bit_cnt), 32'h0);
        clr_n = 1'b1;
        ld_n  = 1'b1;
        repeat (6) @(negedge clk);
        m_dac = '0;
        m_sh  = '0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.dac", 32'(dac_code), 32'h0);
        check("rst.fcnt", 32'(frame_cnt), 32'h0);
        check("rst.bcnt", 32'(bit_cnt), 32'h0);
        check("rst.cv", 32'(code_valid), 32'h0);
        check("rst.fe", 32'(frame_err), 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        m_dac = '0;
        m_sh  = '0;
        m_cnt = 0;
        m_fcnt = '0;
    endtask

    initial begin
        int op;
        int n;
        do_reset();

        send_bits(12, 32'h555);
        do_load();
        verify("load555");

        send_bits(11, 32'h2AA);
        do_load();
        verify("short11");

        send_bits(12, 32'hABC);
        do_load();
        verify("loadABC");
        do_clear(1'b0);
        verify("clear");

        send_bits(12, 32'h123);
        do_clear(1'b1);
        verify("clr_ld");

        send_bits(12, 32'h0F0);
        do_load();
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        m_fcnt = 16'hFFFF;
        send_bits(12, 32'h321);
        do_load();
        verify("wrap");

        send_bits(6, 32'h3F);
        do_reset();
        send_bits(12, 32'hFFF);
        do_load();
        verify("post_rst");

        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 6) begin
                n = (op < 4) ? 12 : int'($urandom_range(1, 17));
                send_bits(n, $urandom);
                do_load();
            end else if (op < 8) begin
                send_bits(int'($urandom_range(0, 16)), $urandom);
                verify("rnd_shift");
                do_load();
            end else begin
                send_bits(int'($urandom_range(0, 13)), $urandom);
                do_clear(op[0]);
            end
            verify("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
